// File: rtl/sparrow_mem_arbiter.sv
// sparrow_mem_arbiter: instr/data share one in-order memory port.
// Optional starvation guard: define SPARROW_ARB_STARVE_GUARD_EN.
module sparrow_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_en_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_wr_data_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam logic       ID_INSTR = 1'b0;
  localparam logic       ID_DATA  = 1'b1;
  localparam logic [3:0] DEPTH    = 4'(MAX_OUTSTANDING);
  localparam logic [2:0] LAST     = 3'(MAX_OUTSTANDING - 1);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8 ||
      STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_cfg
    $error("sparrow_mem_arbiter: parameter out of range");
  end

  logic [3:0] cnt_q;
  logic [2:0] wr_ptr_q;
  logic [2:0] rd_ptr_q;
  logic [7:0] id_q;
  logic       lock_q;
  logic       owner_q;
  logic       err_q;
  logic       sel_data;
  logic       starve_force;
  logic       full;
  logic       grant;
  logic       push;
  logic       pop;
  logic       head_id;

  function automatic logic [2:0] nxt(input logic [2:0] p);
    return (p == LAST) ? 3'd0 : p + 3'd1;
  endfunction

`ifdef SPARROW_ARB_STARVE_GUARD_EN
  logic [7:0] starve_q;

  assign starve_force = instr_req_i &
                        (starve_q == 8'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (!instr_req_i || instr_gnt_o) begin
      starve_q <= '0;
    end else if (!starve_force) begin
      starve_q <= starve_q + 8'd1;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // A registered owner beats the starvation guard so the bus stays stable.
  always_comb begin
    sel_data = ID_INSTR;
    priority case (1'b1)
      lock_q:       sel_data = owner_q;
      starve_force: sel_data = ID_INSTR;
      default:      sel_data = data_req_i;
    endcase
  end

  assign full      = (cnt_q == DEPTH);
  assign mem_req_o = reset_n & (instr_req_i | data_req_i) & ~full;
  assign grant     = mem_req_o & mem_gnt_i;
  assign push      = grant;
  assign pop       = reset_n & mem_rvalid_i & (cnt_q != 4'd0);
  assign head_id   = id_q[rd_ptr_q];

  assign instr_gnt_o = grant & (sel_data == ID_INSTR);
  assign data_gnt_o  = grant & (sel_data == ID_DATA);

  assign mem_addr_o    = !reset_n ? '0 :
                         sel_data ? data_addr_i : instr_addr_i;
  assign mem_byte_en_o = !reset_n ? '0 :
                         sel_data ? data_byte_en_i : 2'b10;
  assign mem_wr_o      = reset_n & sel_data & data_wr_i;
  assign mem_wr_data_o = (reset_n && sel_data) ? data_wr_data_i : '0;

  assign instr_rvalid_o = pop & (head_id == ID_INSTR);
  assign data_rvalid_o  = pop & (head_id == ID_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
  assign err_o          = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      id_q     <= '0;
    end else begin
      if (push) begin
        id_q[wr_ptr_q] <= sel_data;
        wr_ptr_q       <= nxt(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= nxt(rd_ptr_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 4'd1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q  <= 1'b0;
      owner_q <= ID_INSTR;
    end else if (grant) begin
      lock_q <= 1'b0;
    end else if (mem_req_o) begin
      lock_q  <= 1'b1;
      owner_q <= sel_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (mem_rvalid_i && cnt_q == 4'd0) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sparrow_mem_arbiter.sv
// Directed bench for sparrow_mem_arbiter (default parameters).
// Expectations follow SPARROW_ARB_STARVE_GUARD_EN when defined.
module tb_sparrow_mem_arbiter;

`ifdef SPARROW_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic [1:0]  data_byte_en_i;
  logic        data_wr_i;
  logic [31:0] data_wr_data_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [1:0]  mem_byte_en_o;
  logic        mem_wr_o;
  logic [31:0] mem_wr_data_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sparrow_mem_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_byte_en_i (data_byte_en_i),
    .data_wr_i      (data_wr_i),
    .data_wr_data_i (data_wr_data_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_byte_en_o  (mem_byte_en_o),
    .mem_wr_o       (mem_wr_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .err_o          (err_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // inputs change at negedge, outputs sampled 1ns later
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset_n        = 1'b0;
    instr_req_i    = 1'b1;
    instr_addr_i   = 32'h1000;
    data_req_i     = 1'b0;
    data_addr_i    = '0;
    data_byte_en_i = '0;
    data_wr_i      = 1'b0;
    data_wr_data_i = '0;
    mem_gnt_i      = 1'b1;
    mem_rvalid_i   = 1'b0;
    mem_rdata_i    = '0;

    // reset state
    step(); #1;
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_instr_gnt", 32'(instr_gnt_o), 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_byte_en", 32'(mem_byte_en_o), 0);
    chk("rst_err", 32'(err_o), 0);
    instr_req_i = 1'b0;
    mem_gnt_i   = 1'b0;
    step();
    reset_n = 1'b1;

    // single fetch
    step();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h1000;
    mem_gnt_i    = 1'b1;
    #1;
    chk("fetch_gnt", 32'(instr_gnt_o), 1);
    chk("fetch_req", 32'(mem_req_o), 1);
    chk("fetch_addr", mem_addr_o, 32'h1000);
    chk("fetch_be", 32'(mem_byte_en_o), 2);
    chk("fetch_wr", 32'(mem_wr_o), 0);
    step();
    instr_req_i = 1'b0;
    mem_gnt_i   = 1'b0;
    #1;
    chk("idle_rdata", instr_rdata_o, 0);
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0013;
    #1;
    chk("fetch_rvalid", 32'(instr_rvalid_o), 1);
    chk("fetch_rdata", instr_rdata_o, 32'h13);
    chk("fetch_d_rvalid", 32'(data_rvalid_o), 0);
    chk("fetch_d_rdata", data_rdata_o, 0);
    step();
    mem_rvalid_i = 1'b0;

    // contention: data first
    instr_req_i    = 1'b1;
    instr_addr_i   = 32'h2000;
    data_req_i     = 1'b1;
    data_addr_i    = 32'h3000;
    data_byte_en_i = 2'b01;
    data_wr_i      = 1'b1;
    data_wr_data_i = 32'hDEAD_BEEF;
    mem_gnt_i      = 1'b1;
    #1;
    chk("cont_d_gnt", 32'(data_gnt_o), 1);
    chk("cont_i_gnt", 32'(instr_gnt_o), 0);
    chk("cont_addr", mem_addr_o, 32'h3000);
    chk("cont_wr", 32'(mem_wr_o), 1);
    chk("cont_wdata", mem_wr_data_o, 32'hDEAD_BEEF);
    chk("cont_be", 32'(mem_byte_en_o), 1);
    step();
    data_req_i = 1'b0;
    #1;
    chk("cont_i_gnt2", 32'(instr_gnt_o), 1);
    chk("cont_addr2", mem_addr_o, 32'h2000);
    chk("cont_wdata2", mem_wr_data_o, 0);
    chk("cont_wr2", 32'(mem_wr_o), 0);
    step();
    instr_req_i  = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hAAAA_0001;
    #1;
    chk("cont_rsp1_d", 32'(data_rvalid_o), 1);
    chk("cont_rsp1_data", data_rdata_o, 32'hAAAA_0001);
    chk("cont_rsp1_i", 32'(instr_rvalid_o), 0);
    step();
    mem_rdata_i = 32'hBBBB_0002;
    #1;
    chk("cont_rsp2_i", 32'(instr_rvalid_o), 1);
    chk("cont_rsp2_data", instr_rdata_o, 32'hBBBB_0002);
    step();
    mem_rvalid_i = 1'b0;

    // lock holds the instruction request
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h4000;
    #1;
    chk("lock_req", 32'(mem_req_o), 1);
    chk("lock_addr0", mem_addr_o, 32'h4000);
    step();
    data_req_i  = 1'b1;
    data_addr_i = 32'h5000;
    data_wr_i   = 1'b0;
    #1;
    chk("lock_addr1", mem_addr_o, 32'h4000);
    chk("lock_d_gnt0", 32'(data_gnt_o), 0);
    step();
    mem_gnt_i = 1'b1;
    #1;
    chk("lock_i_gnt", 32'(instr_gnt_o), 1);
    chk("lock_d_gnt1", 32'(data_gnt_o), 0);
    chk("lock_addr2", mem_addr_o, 32'h4000);
    step();
    instr_req_i = 1'b0;
    #1;
    chk("lock_d_gnt2", 32'(data_gnt_o), 1);
    chk("lock_addr3", mem_addr_o, 32'h5000);
    step();
    data_req_i   = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_1111;
    #1;
    chk("lock_rsp_i", 32'(instr_rvalid_o), 1);
    step();
    mem_rdata_i = 32'h2222_2222;
    #1;
    chk("lock_rsp_d", 32'(data_rvalid_o), 1);
    chk("lock_rsp_data", data_rdata_o, 32'h2222_2222);
    step();
    mem_rvalid_i = 1'b0;

    // starvation: one response per cycle keeps one outstanding
    data_req_i   = 1'b1;
    data_addr_i  = 32'h6000;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h7000;
    mem_gnt_i    = 1'b1;
    mem_rdata_i  = 32'h0;
    for (int i = 1; i <= 9; i++) begin
      if (i >= 2) mem_rvalid_i = 1'b1;
      #1;
      chk($sformatf("starve_d_gnt%0d", i), 32'(data_gnt_o),
          (GUARD && i == 9) ? 0 : 1);
      chk($sformatf("starve_i_gnt%0d", i), 32'(instr_gnt_o),
          (GUARD && i == 9) ? 1 : 0);
      step();
    end
    data_req_i  = 1'b0;
    instr_req_i = 1'b0;
    mem_gnt_i   = 1'b0;
    #1;
    chk("starve_last_rsp_i", 32'(instr_rvalid_o), GUARD ? 1 : 0);
    chk("starve_last_rsp_d", 32'(data_rvalid_o), GUARD ? 0 : 1);
    step();
    mem_rvalid_i = 1'b0;

    // full and error
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h8000;
    mem_gnt_i    = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("full_gnt%0d", i), 32'(instr_gnt_o), 1);
      step();
    end
    #1;
    chk("full_req", 32'(mem_req_o), 0);
    chk("full_gnt5", 32'(instr_gnt_o), 0);
    step();
    instr_req_i  = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      mem_rdata_i = 32'(i) * 32'h100;
      #1;
      chk($sformatf("full_rsp%0d", i), 32'(instr_rvalid_o), 1);
      chk($sformatf("full_rdata%0d", i), instr_rdata_o, 32'(i) * 32'h100);
      step();
    end
    mem_rdata_i = 32'h5555_5555;
    #1;
    chk("err_rsp_drop", 32'(instr_rvalid_o), 0);
    chk("err_rdata_zero", instr_rdata_o, 0);
    chk("err_before", 32'(err_o), 0);
    step();
    mem_rvalid_i = 1'b0;
    #1;
    chk("err_set", 32'(err_o), 1);
    step(); step();
    #1;
    chk("err_sticky", 32'(err_o), 1);

    // reset clears error; reset mid-transaction drops the ID
    reset_n = 1'b0;
    #1;
    chk("err_reset", 32'(err_o), 0);
    step();
    reset_n = 1'b1;
    step();
    instr_req_i = 1'b1;
    mem_gnt_i   = 1'b1;
    step();
    instr_req_i = 1'b0;
    mem_gnt_i   = 1'b0;
    reset_n     = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req_o), 0);
    step();
    reset_n = 1'b1;
    step();
    mem_rvalid_i = 1'b1;
    #1;
    chk("rst_mid_rvalid", 32'(instr_rvalid_o), 0);
    step();
    mem_rvalid_i = 1'b0;
    #1;
    chk("rst_mid_err", 32'(err_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
